// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: valid/ready handshake with a 2-entry skid buffer,
// mispredict flush, bubble-safe control zeroing and saturating perf counters.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_EMPTY  | no entry held, out_valid=0, in_ready=1
// ST_ONE    | head entry in main register, in_ready=1
// ST_TWO    | main and skid both full, in_ready=0
module pipe_stage_skid #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state, state_nx;
  logic [DATA_W-1:0] main_data, main_data_nx, skid_data, skid_data_nx;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_nx, skid_ctrl, skid_ctrl_nx;
  logic              acc, deq;

  assign acc = in_valid & in_ready;
  assign deq = out_valid & out_ready;

  always_comb begin
    state_nx     = state;
    main_data_nx = main_data;
    main_ctrl_nx = main_ctrl;
    skid_data_nx = skid_data;
    skid_ctrl_nx = skid_ctrl;
    case (state)
      ST_EMPTY: begin
        if (acc) begin
          state_nx     = ST_ONE;
          main_data_nx = in_data;
          main_ctrl_nx = in_ctrl;
        end
      end
      ST_ONE: begin
        if (acc && deq) begin
          main_data_nx = in_data;
          main_ctrl_nx = in_ctrl;
        end else if (acc) begin
          state_nx     = ST_TWO;
          skid_data_nx = in_data;
          skid_ctrl_nx = in_ctrl;
        end else if (deq) begin
          // Control is zeroed on drain so a bubble never carries stale enables.
          state_nx     = ST_EMPTY;
          main_ctrl_nx = '0;
        end
      end
      ST_TWO: begin
        if (deq) begin
          state_nx     = ST_ONE;
          main_data_nx = skid_data;
          main_ctrl_nx = skid_ctrl;
          skid_data_nx = '0;
          skid_ctrl_nx = '0;
        end
      end
      default: begin
        state_nx     = ST_EMPTY;
        main_ctrl_nx = '0;
      end
    endcase
    if (flush) begin
      state_nx     = ST_EMPTY;
      main_data_nx = '0;
      main_ctrl_nx = '0;
      skid_data_nx = '0;
      skid_ctrl_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nx;
      main_data <= main_data_nx;
      main_ctrl <= main_ctrl_nx;
      skid_data <= skid_data_nx;
      skid_ctrl <= skid_ctrl_nx;
      out_valid <= (state_nx != ST_EMPTY);
      in_ready  <= (state_nx != ST_TWO);
    end
  end

  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign occupancy = state;

  // Counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (!out_valid && out_ready && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 1'b1;
      if (flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus a random
// handshake run against a FIFO scoreboard with saturating counter models.
module tb_pipe_stage_skid;

  localparam int DATA_W = 96;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;
  localparam int CMAX   = 15;
  localparam int EW     = DATA_W + CTRL_W;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

  logic [EW-1:0] q[$];
  int m_stall, m_bubble, m_flush;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; the reference model updates on the same edge.
  task automatic cycle();
    bit acc, deq;
    acc = in_valid && (q.size() < 2);
    deq = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      m_stall = 0; m_bubble = 0; m_flush = 0;
    end else begin
      if (q.size() > 0 && !out_ready && m_stall < CMAX) m_stall++;
      if (q.size() == 0 && out_ready && m_bubble < CMAX) m_bubble++;
      if (flush && m_flush < CMAX) m_flush++;
      if (flush) q.delete();
      else begin
        if (deq) void'(q.pop_front());
        if (acc) q.push_back({in_ctrl, in_data});
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    cycle(); cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
      fails++;
      $display("FAIL reset_hs: valid=%b ready=%b occ=%0d want 0/1/0", out_valid, in_ready, occupancy);
    end
    tests++;
    if (out_data !== '0 || out_ctrl !== '0) begin
      fails++;
      $display("FAIL reset_data: data=%h ctrl=%h want 0", out_data, out_ctrl);
    end
    tests++;
    if (stall_cnt !== '0 || bubble_cnt !== '0 || flush_cnt !== '0) begin
      fails++;
      $display("FAIL reset_cnt: %0d/%0d/%0d want 0", stall_cnt, bubble_cnt, flush_cnt);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = DATA_W'(i); in_ctrl = CTRL_W'(i + 16'h100);
      cycle();
      tests++;
      if (out_valid !== 1'b1 || out_data !== DATA_W'(i) || out_ctrl !== CTRL_W'(i + 16'h100)) begin
        fails++;
        $display("FAIL stream_%0d: valid=%b data=%0h ctrl=%h", i, out_valid, out_data, out_ctrl);
      end
      tests++;
      if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream_occ_%0d: occ=%0d ready=%b want 1/1", i, occupancy, in_ready);
      end
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_skid();
    do_reset();
    in_valid = 1'b1; in_data = 96'hA; in_ctrl = 16'h000A; out_ready = 1'b0;
    cycle();
    in_data = 96'hB; in_ctrl = 16'h000B;
    cycle();
    tests++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 96'hA) begin
      fails++;
      $display("FAIL skid_full: occ=%0d ready=%b data=%0h want 2/0/A", occupancy, in_ready, out_data);
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    tests++;
    if (stall_cnt !== 4'd4 || int'(stall_cnt) != m_stall) begin
      fails++;
      $display("FAIL skid_stall: got %0d want 4", stall_cnt);
    end
    out_ready = 1'b1;
    cycle();
    tests++;
    if (out_data !== 96'hB || out_ctrl !== 16'h000B || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      fails++;
      $display("FAIL skid_drain: data=%0h ready=%b occ=%0d want B/1/1", out_data, in_ready, occupancy);
    end
    cycle();
    tests++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0) begin
      fails++;
      $display("FAIL skid_empty: valid=%b ctrl=%h occ=%0d", out_valid, out_ctrl, occupancy);
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_data = 96'hA1; in_ctrl = 16'hFFFF; out_ready = 1'b0;
    cycle();
    in_data = 96'hB2;
    cycle();
    flush = 1'b1; in_data = 96'hC3;
    cycle();
    flush = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_state: valid=%b ctrl=%h data=%0h occ=%0d ready=%b", out_valid, out_ctrl, out_data, occupancy, in_ready);
    end
    tests++;
    if (flush_cnt !== 4'd1) begin
      fails++;
      $display("FAIL flush_cnt: got %0d want 1", flush_cnt);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if (out_valid !== 1'b0 || out_data === 96'hC3) begin
        fails++;
        $display("FAIL flush_leak_%0d: valid=%b data=%0h want invalid", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1; in_data = 96'h55; in_ctrl = 16'hFFFF; out_ready = 1'b0;
    cycle(); cycle(); cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b1; rst = 1'b0;
    cycle();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== '0 || out_ctrl !== '0) begin
      fails++;
      $display("FAIL rstmid_state: valid=%b ready=%b occ=%0d data=%0h ctrl=%h", out_valid, in_ready, occupancy, out_data, out_ctrl);
    end
    tests++;
    if (flush_cnt !== '0 || stall_cnt !== '0 || bubble_cnt !== '0) begin
      fails++;
      $display("FAIL rstmid_cnt: flush=%0d stall=%0d bubble=%0d want 0", flush_cnt, stall_cnt, bubble_cnt);
    end
  endtask

  task automatic test_bubble_sat();
    do_reset();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      tests++;
      if (out_ctrl !== '0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL bubble_ctrl_%0d: ctrl=%h valid=%b want 0", i, out_ctrl, out_valid);
      end
      tests++;
      if (bubble_cnt !== CNT_W'((i + 1 > CMAX) ? CMAX : i + 1)) begin
        fails++;
        $display("FAIL bubble_cnt_%0d: got %0d want %0d", i, bubble_cnt, (i + 1 > CMAX) ? CMAX : i + 1);
      end
    end
  endtask

  task automatic test_random();
    logic [EW-1:0] head;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      if (!(in_valid && q.size() >= 2)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = {$urandom, $urandom, $urandom};
        in_ctrl  = CTRL_W'($urandom);
      end
      out_ready = (i % 2000 < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 63) == 0);
      cycle();
      tests++;
      if (occupancy !== 2'(q.size()) || in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0)) begin
        fails++;
        if (fails < 30)
          $display("FAIL rnd_hs cyc %0d: occ=%0d ready=%b valid=%b want occ %0d", i, occupancy, in_ready, out_valid, q.size());
      end
      tests++;
      if (q.size() > 0) begin
        head = q[0];
        if ({out_ctrl, out_data} !== head) begin
          fails++;
          if (fails < 30)
            $display("FAIL rnd_data cyc %0d: got %h want %h", i, {out_ctrl, out_data}, head);
        end
      end else if (out_ctrl !== '0) begin
        fails++;
        if (fails < 30)
          $display("FAIL rnd_bubble_ctrl cyc %0d: got %h want 0", i, out_ctrl);
      end
      tests++;
      if (int'(stall_cnt) != m_stall || int'(bubble_cnt) != m_bubble || int'(flush_cnt) != m_flush) begin
        fails++;
        if (fails < 30)
          $display("FAIL rnd_cnt cyc %0d: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                   stall_cnt, bubble_cnt, flush_cnt, m_stall, m_bubble, m_flush);
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    m_stall = 0; m_bubble = 0; m_flush = 0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_reset_mid();
    test_bubble_sat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, elastic successor to the fixed decode/execute pipeline register. Usable at any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the global stall/hold scheme with a valid/ready handshake. A 2-entry skid buffer keeps in_ready registered, so no combinational ready path runs across stages.
- Keeps mispredict flush, bubble-safe zeroing of control bits, and adds saturating performance counters for stall, bubble and flush cycles.

Parameters:
- DATA_W, 96: payload width (operands, immediate, PC); cleared on reset/flush, otherwise transparent.
- CTRL_W, 16: control field width (regWrite, memRead, memWrite, branch, alu_control...); forced to 0 whenever out_valid=0.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- flush  in  1  mispredict flush; kills all held entries and the current input
- in_valid  in  1  upstream has an entry
- in_ready  out  1  stage can accept (registered)
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bits
- out_valid  out  1  stage presents an entry
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  payload of head entry
- out_ctrl  out  CTRL_W  control of head entry; 0 when out_valid=0
- occupancy  out  2  entries held: 0, 1 or 2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1
- flush_cnt  out  CNT_W  cycles with flush=1

Behaviour:
- Reset (rst=0 at posedge) sets:
  - out_valid=0, in_ready=1, occupancy=0
  - out_data=0, out_ctrl=0, skid registers=0
  - all counters=0
- Reset overrides flush and all handshakes, including mid-transfer.
- Handshakes:
  - acc = in_valid & in_ready.
  - deq = out_valid & out_ready.
  - Upstream must hold in_data/in_ctrl while in_valid=1 and in_ready=0.
- Storage: main register (drives out_*) and skid register. in_ready = !skid_valid, registered.
- State machine, with state = occupancy:
  - EMPTY (0):
    - acc -> ONE; main<=in.
  - ONE (1):
    - acc&deq -> ONE; main<=in.
    - acc&!deq -> TWO; skid<=in; in_ready=0 next cycle.
    - !acc&deq -> EMPTY.
    - Otherwise hold.
  - TWO (2), in_ready=0:
    - deq -> ONE; main<=skid; skid cleared; in_ready=1 next cycle.
    - Otherwise hold.
- Latency and throughput:
  - Latency is 1 cycle from acceptance to out_valid.
  - Sustained throughput is 1 entry/cycle while out_ready=1.
  - Order is strictly FIFO; no entry is dropped or duplicated except on flush.
- Flush (rst=1, flush=1 at posedge):
  - Next state is EMPTY: out_valid=0, in_ready=1.
  - main and skid data/ctrl are cleared to 0.
  - An input offered in the flush cycle is discarded, even when in_ready=1.
  - A deq in the flush cycle still counts as a completed transfer for downstream.
  - The flushed state does not depend on acc/deq in that cycle.
- Bubble safety: out_ctrl is 0 whenever out_valid=0, so stale regWrite/memWrite can never leak into later stages.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at 2^CNT_W-1 (no wrap).
  - Flush does not clear counters; only reset does.
  - flush_cnt and stall_cnt may both increment in the same cycle.
- All outputs are registered. There is no combinational path from in_* or out_ready to any output.

Test Plan:
- Reset then stream: rst low 2 cycles, then in_valid=1 with out_ready=1 and in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later each, out_valid=1 continuously, occupancy=1, in_ready stays 1.
- Backpressure/skid: with the stage holding A, drop out_ready while B is offered -> B goes to skid, occupancy=2, in_ready=0 next cycle, stall_cnt +1 per held cycle. Raise out_ready -> A then B appear in order, in_ready=1 one cycle after A's deq.
- Flush with full buffer: occupancy=2 with ctrl=16'hFFFF, assert flush while in_valid=1 with C -> next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0, flush_cnt=1, and C never appears at the output.
- Reset mid-operation: occupancy=2 and flush=1 with rst=0 -> all outputs at reset values, flush_cnt=0.
- Bubble and saturation with CNT_W=4: out_ready=1 and in_valid=0 for 20 cycles -> bubble_cnt=15 and holds; out_ctrl=0 throughout.
- Random handshake: random in_valid/out_ready for 10k cycles against a reference FIFO model -> zero mismatches, occupancy never exceeds 2, in_ready==(occupancy<2).
